// File: rtl/key_src.sv
// Bus-programmable key source: software pushes 9-bit key words into a FIFO that
// drains onto a valid/accept stream. Exposes fill/overflow status and enable/flush control.
module key_src #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        main_clk_i,
  input  logic        main_rst_i,
  input  logic [1:0]  bus_trans_i,
  input  logic [31:0] bus_addr_i,
  input  logic        bus_write_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_ready_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_o,
  output logic        key_valid_o,
  input  logic        key_accept_i,
  output logic [8:0]  key_data_o
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [4:0]  FullLvl = 5'(DEPTH);

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  logic [8:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      level_q, level_d;
  logic            enable_q, enable_d;
  logic            overflow_q, overflow_d;
  logic            ready_q;
  logic            resp_q, resp_d;
  logic [31:0]     rdata_q, rdata_d;

  logic       accept, addr_ok, rd_req;
  logic [1:0] reg_sel;
  logic       wr_data, wr_status, wr_ctrl;
  logic       full, empty, key_valid, pop, push, flush;

  logic unused_bits;
  assign unused_bits = ^{bus_wdata_i[31:11], bus_wdata_i[9], bus_trans_i[0]};

  // Request decode and FIFO handshake qualifiers
  always_comb begin
    accept    = bus_trans_i[1] & ~ready_q;
    reg_sel   = bus_addr_i[3:2];
    addr_ok   = (bus_addr_i[31:4] == 28'd0) && (bus_addr_i[1:0] == 2'd0) &&
                (reg_sel != 2'd3);
    wr_data   = accept & addr_ok & bus_write_i & (reg_sel == RegData);
    wr_status = accept & addr_ok & bus_write_i & (reg_sel == RegStatus);
    wr_ctrl   = accept & addr_ok & bus_write_i & (reg_sel == RegCtrl);
    rd_req    = accept & addr_ok & ~bus_write_i;

    full      = (level_q == FullLvl);
    empty     = (level_q == 5'd0);
    key_valid = enable_q & ~empty;
    pop       = key_valid & key_accept_i;
    // Fullness is judged before any coincident pop, so a push into a full FIFO is dropped
    push      = wr_data & ~full;
    flush     = wr_ctrl & bus_wdata_i[1];
  end

  // Next-state for pointers, level and control/status bits
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    level_d = level_q + 5'(push) - 5'(pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 5'd0;
    end
    if (wr_ctrl) begin
      enable_d = bus_wdata_i[0];
    end
    if (wr_data && full) begin
      overflow_d = 1'b1;
    end
    if (wr_status && bus_wdata_i[10]) begin
      overflow_d = 1'b0;
    end
  end

  // Response payload; reads reflect the state after the accepting edge
  always_comb begin
    resp_d  = accept & (~addr_ok | (wr_data & full));
    rdata_d = 32'd0;
    if (rd_req) begin
      unique case (reg_sel)
        RegStatus: rdata_d = {21'd0, overflow_d, (level_d == FullLvl), (level_d == 5'd0),
                              3'd0, level_d};
        RegCtrl:   rdata_d = {31'd0, enable_d};
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      ready_q    <= accept;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the level is non-zero
  always_ff @(posedge main_clk_i) begin
    if (!main_rst_i && push) begin
      mem_q[wr_ptr_q] <= bus_wdata_i[8:0];
    end
  end

  assign bus_ready_o = ready_q;
  assign bus_resp_o  = resp_q;
  assign bus_rdata_o = rdata_q;
  assign key_valid_o = key_valid;
  assign key_data_o  = key_valid ? mem_q[rd_ptr_q] : 9'd0;

endmodule

// File: tb/tb_key_src.sv
// Self-checking bench for key_src: queue-based reference model with a scoreboard for bus
// responses and a per-cycle stream monitor, plus directed scenarios and a random phase.
module tb_key_src;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  bus_trans;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_resp;
  logic [31:0] bus_rdata;
  logic        key_valid;
  logic        key_accept;
  logic [8:0]  key_data;

  key_src #(.DEPTH(DEPTH)) dut (
    .main_clk_i  (clk),
    .main_rst_i  (rst),
    .bus_trans_i (bus_trans),
    .bus_addr_i  (bus_addr),
    .bus_write_i (bus_write),
    .bus_wdata_i (bus_wdata),
    .bus_ready_o (bus_ready),
    .bus_resp_o  (bus_resp),
    .bus_rdata_o (bus_rdata),
    .key_valid_o (key_valid),
    .key_accept_i(key_accept),
    .key_data_o  (key_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model state
  logic [8:0]  mq[$];
  bit          m_en, m_ov, m_pend;
  logic [32:0] exp_bus[$];
  logic [8:0]  seen[$];

  // Stream-accept driver: 0 low, 1 high, 2 random, 3 follow manual_acc
  int acc_mode = 0;
  bit manual_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (acc_mode)
      0:       key_accept = 1'b0;
      1:       key_accept = 1'b1;
      2:       key_accept = 1'($urandom_range(0, 1));
      default: key_accept = manual_acc;
    endcase
  end

  // Model: applies the register/FIFO rules at each edge and queues the expected response
  bit          mp_pop, mp_acc, mp_full0, mp_legal;
  logic [32:0] mp_rsp;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_bus.delete();
      m_en   = 1'b0;
      m_ov   = 1'b0;
      m_pend = 1'b0;
    end else begin
      mp_pop   = m_en && (mq.size() > 0) && key_accept;
      mp_full0 = (mq.size() == DEPTH);
      mp_acc   = bus_trans[1] && !m_pend;
      if (mp_pop) void'(mq.pop_front());
      if (mp_acc) begin
        mp_legal = (bus_addr < 32'd12) && (bus_addr % 4 == 0);
        mp_rsp   = {1'b1, 32'd0};
        if (mp_legal) begin
          mp_rsp = '0;
          case (bus_addr)
            32'd0: if (bus_write) begin
              if (mp_full0) begin
                m_ov       = 1'b1;
                mp_rsp[32] = 1'b1;
              end else begin
                mq.push_back(bus_wdata[8:0]);
              end
            end
            32'd4: if (bus_write) begin
              if (bus_wdata[10]) m_ov = 1'b0;
            end else begin
              mp_rsp[31:0] = 32'(mq.size()) | (32'(mq.size() == 0) << 8) |
                             (32'(mq.size() == DEPTH) << 9) | (32'(m_ov) << 10);
            end
            default: if (bus_write) begin
              m_en = bus_wdata[0];
              if (bus_wdata[1]) mq.delete();
            end else begin
              mp_rsp[31:0] = 32'(m_en);
            end
          endcase
        end
        exp_bus.push_back(mp_rsp);
      end
      m_pend = mp_acc;
    end
  end

  // Bus scoreboard monitor
  logic [32:0] mb_e;
  always @(negedge clk) begin
    if (mon_on) begin
      chk("bus_ready", 32'(bus_ready), 32'(m_pend));
      if (bus_ready) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected_ready", 32'(bus_ready), 32'd0);
        end else begin
          mb_e = exp_bus.pop_front();
          chk("bus_resp", 32'(bus_resp), 32'(mb_e[32]));
          chk("bus_rdata", bus_rdata, mb_e[31:0]);
        end
      end else begin
        chk("bus_idle_resp", 32'(bus_resp), 32'd0);
        chk("bus_idle_rdata", bus_rdata, 32'd0);
      end
    end
  end

  // Stream monitor
  bit kv_exp;
  always @(negedge clk) begin
    if (mon_on) begin
      kv_exp = m_en && (mq.size() > 0);
      chk("key_valid", 32'(key_valid), 32'(kv_exp));
      if (kv_exp) chk("key_data", 32'(key_data), 32'(mq[0]));
      else        chk("key_data_idle", 32'(key_data), 32'd0);
      if (key_valid && key_accept) seen.push_back(key_data);
    end
  end

  task automatic bus_start(input logic [31:0] a, input bit w, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus_trans = {1'b1, 1'($urandom_range(0, 1))};
    bus_addr  = a;
    bus_write = w;
    bus_wdata = d;
  endtask

  task automatic bus_wait(output bit r, output logic [31:0] rd);
    bit got = 1'b0;
    r  = 1'b0;
    rd = 32'd0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus_ready) begin
        got = 1'b1;
        r   = bus_resp;
        rd  = bus_rdata;
      end
    end
    bus_trans = {1'b0, 1'($urandom_range(0, 1))};
    chk("bus_timeout", 32'(got), 32'd1);
  endtask

  task automatic bus_op(input logic [31:0] a, input bit w, input logic [31:0] d,
                        output bit r, output logic [31:0] rd);
    bus_start(a, w, d);
    bus_wait(r, rd);
  endtask

  bit          r;
  logic [31:0] rd;
  logic [31:0] bad_addrs[8];
  int          sel;

  initial begin
    rst = 1'b1;
    bus_trans = 2'b00; bus_addr = '0; bus_write = 1'b0; bus_wdata = '0;
    key_accept = 1'b0;
    bad_addrs = '{32'h0C, 32'h10, 32'h01, 32'h02, 32'h03, 32'h104, 32'h8000_0000, 32'h0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_data", 32'(key_data), 32'd0);
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("rst_status_resp", 32'(r), 32'd0);
    chk("rst_status", rd, 32'h100);

    // Queued words stream out one per cycle once enabled
    acc_mode = 1;
    bus_op(32'h0, 1'b1, 32'h1A5, r, rd);
    bus_op(32'h0, 1'b1, 32'h003, r, rd);
    bus_op(32'h0, 1'b1, 32'h0FF, r, rd);
    seen.delete();
    bus_op(32'h8, 1'b1, 32'h1, r, rd);
    repeat (4) @(negedge clk);
    chk("seq_len", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("seq0", 32'(seen[0]), 32'h1A5);
      chk("seq1", 32'(seen[1]), 32'h003);
      chk("seq2", 32'(seen[2]), 32'h0FF);
    end
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("drained_status", rd, 32'h100);

    // Overflow on the ninth push
    acc_mode = 0;
    bus_op(32'h8, 1'b1, 32'h0, r, rd);
    for (int i = 0; i < 9; i++) begin
      bus_op(32'h0, 1'b1, 32'(i + 16), r, rd);
      chk("fill_resp", 32'(r), (i < 8) ? 32'd0 : 32'd1);
    end
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("full_status", rd, 32'h608);
    bus_op(32'h4, 1'b1, 32'h400, r, rd);
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("ovf_cleared", rd, 32'h208);

    // Push into a full FIFO coincident with a pop
    acc_mode   = 3;
    manual_acc = 1'b0;
    bus_op(32'h8, 1'b1, 32'h1, r, rd);
    @(negedge clk);
    manual_acc = 1'b1;
    bus_start(32'h0, 1'b1, 32'h1EE);
    @(negedge clk);
    manual_acc = 1'b0;
    bus_wait(r, rd);
    chk("full_pop_resp", 32'(r), 32'd1);
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("full_pop_status", rd, 32'h407);

    // Flush
    acc_mode = 0;
    bus_op(32'h4, 1'b1, 32'h400, r, rd);
    bus_op(32'h8, 1'b1, 32'h2, r, rd);
    for (int i = 0; i < 5; i++) bus_op(32'h0, 1'b1, 32'(i * 7), r, rd);
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("five_status", rd, 32'h005);
    bus_op(32'h8, 1'b1, 32'h3, r, rd);
    chk("flush_valid", 32'(key_valid), 32'd0);
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("flush_status", rd, 32'h100);
    bus_op(32'h8, 1'b0, 32'd0, r, rd);
    chk("ctrl_read", rd, 32'h1);

    // Bad addresses have no side effect
    bus_op(32'h0, 1'b1, 32'h055, r, rd);
    bus_op(32'h0, 1'b1, 32'h0AA, r, rd);
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("pre_bad_status", rd, 32'h002);
    for (int i = 0; i < 3; i++) begin
      bus_op(bad_addrs[i], 1'b0, 32'd0, r, rd);
      chk("bad_rd_resp", 32'(r), 32'd1);
      chk("bad_rd_data", rd, 32'd0);
      bus_op(bad_addrs[i], 1'b1, 32'h403, r, rd);
      chk("bad_wr_resp", 32'(r), 32'd1);
    end
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("post_bad_status", rd, 32'h002);

    // Reset coincident with request acceptance
    @(posedge clk);
    #1;
    bus_trans = 2'b10; bus_addr = 32'h4; bus_write = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 bus_trans = 2'b00;
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus_ready), 32'd0);
    chk("rst_mid_rdata", bus_rdata, 32'd0);
    chk("rst_mid_valid", 32'(key_valid), 32'd0);
    chk("rst_mid_data", 32'(key_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ready", 32'(bus_ready), 32'd0);
    end
    bus_op(32'h4, 1'b0, 32'd0, r, rd);
    chk("rst_mid_status", rd, 32'h100);

    // Random traffic against the model
    acc_mode = 2;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: bus_op(32'h0, 1'b1, $urandom, r, rd);
        4:          bus_op(32'h4, 1'b0, $urandom, r, rd);
        5:          bus_op(32'h4, 1'b1, $urandom, r, rd);
        6:          bus_op(32'h8, 1'b1, {30'($urandom), ($urandom_range(0, 5) == 0),
                                         ($urandom_range(0, 3) != 0)}, r, rd);
        7:          bus_op(32'h8, 1'b0, $urandom, r, rd);
        8:          bus_op((sel == 8 && $urandom_range(0, 7) == 7) ? ($urandom | 32'h1)
                                                                   : bad_addrs[$urandom_range(0, 6)],
                           1'($urandom_range(0, 1)), $urandom, r, rd);
        default:    bus_op(32'h0, 1'b0, $urandom, r, rd);
      endcase
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_src.md
Name: key_src

Overview:
Bus-programmable key source that sits directly upstream of the top-level key_i port group.
- Software pushes 9-bit key words through the bus register interface into an internal FIFO.
- The block presents them on a valid/accept stream to the key consumer.
- Exposes fill/overflow status and enable/flush control.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..16.

Ports:
main_clk_i  input  1  clock, rising edge
main_rst_i  input  1  reset, synchronous, active-high
bus_trans_i  input  2  transfer type; bit1=1 requests a transfer, 00/01 idle
bus_addr_i  input  32  byte address; bits [3:2] select register
bus_write_i  input  1  1=write, 0=read
bus_wdata_i  input  32  write data
bus_ready_o  output  1  one-cycle response strobe
bus_resp_o  output  1  0=OK, 1=error; valid with bus_ready_o
bus_rdata_o  output  32  read data; valid with bus_ready_o
key_valid_o  output  1  key word available
key_accept_i  input  1  consumer takes word when key_valid_o=1
key_data_o  output  9  key word

Behaviour:
Reset (main_rst_i=1 at a clock edge, synchronous, active-high):
- All outputs 0.
- FIFO empty, enable=0, overflow=0.
- Any pending response is discarded.

Bus protocol:
- Request accepted on an edge where bus_trans_i[1]=1 and no response is pending.
- bus_ready_o=1 for exactly one cycle, the cycle after acceptance.
- bus_resp_o and bus_rdata_o are registered and valid only while bus_ready_o=1; otherwise 0.
- No request is accepted in the bus_ready_o cycle, so max rate is 1 access per 2 cycles.
- The requester holds a request until bus_ready_o.
- Only bits [31:4]=0 and [1:0]=0 decode; any other address, or offset 0xC, returns resp=1, rdata=0, no side effect.

Registers:
- 0x0 DATA
  - Write: push wdata[8:0]. If FIFO is full at acceptance, the word is dropped, overflow is set, resp=1.
  - Read: rdata=0, resp=0.
- 0x4 STATUS (read)
  - [4:0] level
  - [8] empty
  - [9] full
  - [10] overflow (sticky)
  - other bits 0
- 0x4 STATUS (write)
  - wdata[10]=1 clears overflow; other bits ignored.
- 0x8 CTRL
  - [0] enable, RW.
  - [1] flush: write-1 empties FIFO at that edge (level=0, pointers reset); reads 0.
  - Overflow is unaffected by flush.

Stream:
- key_valid_o = enable & !empty.
- key_data_o = FIFO head when key_valid_o=1, else 0.
- Pop on any edge with key_valid_o & key_accept_i.
- key_data_o stays stable while valid and not accepted.

FIFO:
- Read/write pointers wrap modulo DEPTH; level counts 0..DEPTH.
- Push and pop in the same cycle:
  - If full at acceptance, the push is dropped (fullness is evaluated before the pop) and the pop proceeds: level goes DEPTH to DEPTH-1.
  - Otherwise level is unchanged.
- Flush coincident with pop: FIFO ends empty; the popped word still counts as delivered.
- Clearing enable:
  - key_valid_o drops the next cycle.
  - FIFO contents are retained.
  - A handshake completed in the current cycle still pops.

Latency:
- DATA write accepted at edge N:
  - Word is in the FIFO after edge N.
  - key_valid_o can rise in cycle N+1 if enabled.
  - bus_ready_o=1 in cycle N+1.
- Status read reflects state after edge N.

Reset mid-operation: the FIFO empties, no bus_ready_o follows the aborted request, and the requester must reissue it.

Test Plan:
- Reset, then read STATUS at 0x4 -> ready one cycle after acceptance, resp=0, rdata=0x100 (empty); key_valid_o=0, key_data_o=0.
- CTRL=1, write DATA 0x1A5, 0x003, 0x0FF, key_accept_i held 1 -> key_data_o sequence 0x1A5, 0x003, 0x0FF, one per cycle; then key_valid_o=0 and STATUS=0x100.
- enable=0, push 9 words (DEPTH=8) -> writes 1-8 resp=0, 9th resp=1; STATUS=0x608 (full, overflow, level 8); write 0x400 to STATUS -> STATUS=0x208.
- FIFO full, enable=1, key_accept_i=1 during a DATA write -> write resp=1, word dropped, level 8 to 7, overflow set.
- Fill 5 words, write CTRL=0x3 (flush+enable) -> key_valid_o=0 next cycle, STATUS level=0, CTRL reads 0x1.
- Read at 0x0C, 0x10, and 0x01 -> resp=1, rdata=0, no state change; reset asserted mid-request -> no bus_ready_o, all outputs 0.
